hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameters SHALL be: NUM_REGS 32, number of architectural registers; AW 5, register address width; NUM_SRC 2, source read ports; LW 3, latency counter width; ECALL_REG 17, register checked for ecall hazards.
REQ-002 Ports SHALL be, in order: clk input 1 clock; reset input 1 reset.
REQ-003 Clock and reset SHALL be exactly as decided: one clock; reset is asynchronous and active-high.
REQ-004 issue_valid input 1 SHALL mean an instruction is presented for issue this cycle.
REQ-005 issue_rd input AW SHALL be the destination register; issue_wen input 1 SHALL mean the instruction writes rd.
REQ-006 issue_lat input LW SHALL give the cycles until the result can be forwarded; 0 means it is forwardable immediately.
REQ-007 src_valid input NUM_SRC SHALL give per-port source-use flags; src_addr input NUM_SRC*AW SHALL hold the packed source addresses, port 0 in the LSBs.
REQ-008 is_ecall input 1 SHALL mean the issuing instruction is ecall; flush input 1 SHALL mean the issuing instruction is squashed.
REQ-009 is_stall output 1 SHALL hold issue; busy_mask output NUM_REGS SHALL hold one bit per register whose counter is nonzero.
REQ-010 stall_cycles output 32 SHALL be the performance counter described under Configuration.

Function
REQ-011 Storage SHALL be one LW-bit countdown counter per register.
REQ-012 Register 0 SHALL never be reserved, its counter SHALL read 0, and sources addressing register 0 SHALL never stall.
REQ-013 RAW: is_stall SHALL assert when any port i has src_valid[i]=1 and the counter for src_addr[i] is nonzero.
REQ-014 Ecall: is_stall SHALL assert when is_ecall=1 and the counter for ECALL_REG is nonzero.
REQ-015 WAW: is_stall SHALL assert when issue_valid=1, issue_wen=1, and the counter for issue_rd is greater than issue_lat.
REQ-016 is_stall SHALL be combinational from the current counters and inputs, with no added latency, and SHALL be 0 when issue_valid=0.
REQ-017 Accept condition: issue_valid=1, is_stall=0, flush=0, issue_wen=1, issue_rd!=0 and issue_lat!=0.
REQ-018 On accept, counter[issue_rd] SHALL load issue_lat at the next edge.
REQ-019 Every other nonzero counter SHALL decrement by 1 per cycle, saturating at 0.
REQ-020 When an accept and a decrement target the same register in the same cycle, the load SHALL win.
REQ-021 A stalled or flushed issue SHALL change no counter, and all other counters SHALL keep decrementing.
REQ-022 Timing: an accept at edge N with latency L SHALL give stalls on that rd during cycles N+1..N+L and no stall from cycle N+L+1.
REQ-023 busy_mask SHALL be registered state, bit r equal to (counter[r]!=0), with bit 0 always 0.

Reset
REQ-024 Asserting reset at any time, including mid-countdown, SHALL clear all counters immediately.
REQ-025 Reset SHALL force busy_mask=0 and stall_cycles=0.
REQ-026 With all counters zero, is_stall SHALL be 0 for any input.
REQ-027 The first accept after reset deassertion SHALL take effect at the first rising edge with reset low.

Configuration
REQ-028 The feature macro SHALL be HAZARD_SCOREBOARD_PERF_EN.
REQ-029 Defined: stall_cycles SHALL increment by 1 each cycle in which issue_valid=1 and is_stall=1, and SHALL saturate at 32'hFFFF_FFFF.
REQ-030 Undefined: stall_cycles SHALL be tied to 0, and no counter flops SHALL be synthesised.

Structure
REQ-031 Package hazard_pkg SHALL hold the default parameters NUM_REGS, AW, LW and NUM_SRC, plus the constant ECALL_REG=17.
REQ-032 Package hazard_pkg SHALL hold the constant REG_ZERO=0.
REQ-033 Sub-module scoreboard_entry SHALL implement one counter (load, decrement, zero flag) and SHALL be instantiated NUM_REGS-1 times by generate, with no instance for register 0.

Verification
REQ-034 Load-use: accept rd=5, lat=1; next cycle src0=5 -> is_stall=1 for 1 cycle, 0 in the cycle after.
REQ-035 Long latency: accept rd=7, lat=4; src1=7 held -> is_stall=1 for exactly 4 cycles; busy_mask[7] high for 4 cycles.
REQ-036 Ecall: accept rd=17, lat=2; is_ecall=1 next cycle -> stall 2 cycles; the same is_ecall with rd=17 idle -> no stall.
REQ-037 WAW and zero register: rd=3 counter=3, then issue rd=3 lat=1 -> stall until counter<=1; issue rd=0 lat=4 -> busy_mask stays 0 and src=0 never stalls.
REQ-038 Flush and reset: flushed accept of rd=9 -> counter[9] stays 0; reset asserted with rd=4 counter=2 -> busy_mask=0 immediately.
REQ-039 With HAZARD_SCOREBOARD_PERF_EN: 6 stalled cycles -> stall_cycles=6, and the value survives until reset. Without the macro: stall_cycles stays 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Default sizing and fixed register indices shared by the hazard scoreboard files.
package hazard_pkg;

    localparam int NUM_REGS  = 32;
    localparam int AW        = 5;
    localparam int LW        = 3;
    localparam int NUM_SRC   = 2;
    localparam int ECALL_REG = 17;
    localparam int REG_ZERO  = 0;

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One per-register countdown: loads a latency, counts down to zero, and keeps a registered busy flag.
module scoreboard_entry #(
    parameter int LW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [LW-1:0] load_val,
    output logic [LW-1:0] count,
    output logic          busy
);

    logic [LW-1:0] count_next;

    // A load takes priority over the decrement in the same cycle.
    always_comb begin
        count_next = count;
        if (load)
            count_next = load_val;
        else if (count != '0)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            busy  <= 1'b0;
        end else begin
            count <= count_next;
            busy  <= (count_next != '0);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard (RAW, WAW, ecall) with per-register latency countdowns.
// Define HAZARD_SCOREBOARD_PERF_EN to enable the stall_cycles performance counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS  = hazard_pkg::NUM_REGS,
    parameter int AW        = hazard_pkg::AW,
    parameter int NUM_SRC   = hazard_pkg::NUM_SRC,
    parameter int LW        = hazard_pkg::LW,
    parameter int ECALL_REG = hazard_pkg::ECALL_REG
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [AW-1:0]         issue_rd,
    input  logic                  issue_wen,
    input  logic [LW-1:0]         issue_lat,
    input  logic [NUM_SRC-1:0]    src_valid,
    input  logic [NUM_SRC*AW-1:0] src_addr,
    input  logic                  is_ecall,
    input  logic                  flush,
    output logic                  is_stall,
    output logic [NUM_REGS-1:0]   busy_mask,
    output logic [31:0]           stall_cycles
);

    logic [LW-1:0] count [NUM_REGS];
    logic          raw_hit;
    logic          ecall_hit;
    logic          waw_hit;
    logic          accept;

    assign count[0]     = '0;
    assign busy_mask[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        scoreboard_entry #(
            .LW(LW)
        ) u_entry (
            .clk      (clk),
            .reset    (reset),
            .load     (accept && (issue_rd == AW'(r))),
            .load_val (issue_lat),
            .count    (count[r]),
            .busy     (busy_mask[r])
        );
    end

    always_comb begin
        raw_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (src_valid[i] && (count[src_addr[i*AW +: AW]] != '0))
                raw_hit = 1'b1;
        end
    end

    assign ecall_hit = is_ecall && (count[ECALL_REG] != '0);
    // A WAW only blocks if the older write would land after the new one.
    assign waw_hit   = issue_wen && (count[issue_rd] > issue_lat);
    assign is_stall  = issue_valid && (raw_hit || ecall_hit || waw_hit);

    assign accept = issue_valid && !is_stall && !flush && issue_wen &&
                    (issue_rd != AW'(REG_ZERO)) && (issue_lat != '0);

`ifdef HAZARD_SCOREBOARD_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cycles <= '0;
        else if (is_stall && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 32'd1;
    end
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard.
module tb_hazard_scoreboard;

    localparam int NUM_REGS = 32;
    localparam int AW       = 5;
    localparam int NUM_SRC  = 2;
    localparam int LW       = 3;

    logic                  clk;
    logic                  reset;
    logic                  issue_valid;
    logic [AW-1:0]         issue_rd;
    logic                  issue_wen;
    logic [LW-1:0]         issue_lat;
    logic [NUM_SRC-1:0]    src_valid;
    logic [NUM_SRC*AW-1:0] src_addr;
    logic                  is_ecall;
    logic                  flush;
    logic                  is_stall;
    logic [NUM_REGS-1:0]   busy_mask;
    logic [31:0]           stall_cycles;

    int checks = 0;
    int errors = 0;

    hazard_scoreboard #(
        .NUM_REGS  (NUM_REGS),
        .AW        (AW),
        .NUM_SRC   (NUM_SRC),
        .LW        (LW),
        .ECALL_REG (17)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_wen    (issue_wen),
        .issue_lat    (issue_lat),
        .src_valid    (src_valid),
        .src_addr     (src_addr),
        .is_ecall     (is_ecall),
        .flush        (flush),
        .is_stall     (is_stall),
        .busy_mask    (busy_mask),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [AW-1:0] rd, input logic wen,
                         input logic [LW-1:0] lat, input logic [1:0] sv,
                         input logic [AW-1:0] s1, input logic [AW-1:0] s0,
                         input logic ec, input logic fl);
        issue_valid = v;
        issue_rd    = rd;
        issue_wen   = wen;
        issue_lat   = lat;
        src_valid   = sv;
        src_addr    = {s1, s0};
        is_ecall    = ec;
        flush       = fl;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 3'd0, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    // advance one edge, then settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 5'd5, 1'b1, 3'd3, 2'b11, 5'd5, 5'd5, 1'b1, 1'b0);
        #2;
        checks++;
        if (busy_mask !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h want %h", busy_mask, 32'h0); end
        checks++;
        if (is_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", is_stall); end
        checks++;
        if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_perf: got %0d want 0", stall_cycles); end
        tick();
        tick();
        sample();
        checks++;
        if (busy_mask !== 32'h0) begin errors++; $display("FAIL reset_held_busy: got %h want %h", busy_mask, 32'h0); end
        tick();
        reset = 1'b0;
        idle();
    endtask

    task automatic test_load_use();
        drive(1'b1, 5'd5, 1'b1, 3'd1, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
        sample();
        checks++;
        if (is_stall !== 1'b0) begin errors++; $display("FAIL lu_issue_stall: got %b want 0", is_stall); end
        tick();
        drive(1'b1, 5'd0, 1'b0, 3'd0, 2'b01, 5'd0, 5'd5, 1'b0, 1'b0);
        sample();
        checks++;
        if (is_stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b want 1", is_stall); end
        checks++;
        if (busy_mask !== 32'h0000_0020) begin errors++; $display("FAIL lu_busy: got %h want %h", busy_mask, 32'h20); end
        tick();
        sample();
        checks++;
        if (is_stall !== 1'b0) begin errors++; $display("FAIL lu_release: got %b want 0", is_stall); end
        idle();
    endtask

    task automatic test_long_latency();
        drive(1'b1, 5'd7, 1'b1, 3'd4, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b0, 3'd0, 2'b10, 5'd7, 5'd0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            sample();
            checks++;
            if (is_stall !== 1'b1) begin errors++; $display("FAIL ll_stall_%0d: got %b want 1", k, is_stall); end
            checks++;
            if (busy_mask[7] !== 1'b1) begin errors++; $display("FAIL ll_busy_%0d: got %b want 1", k, busy_mask[7]); end
            tick();
        end
        sample();
        checks++;
        if (is_stall !== 1'b0) begin errors++; $display("FAIL ll_release: got %b want 0", is_stall); end
        checks++;
        if (busy_mask !== 32'h0) begin errors++; $display("FAIL ll_busy_clear: got %h want 0", busy_mask); end
        idle();
    endtask

    task automatic test_ecall();
        drive(1'b1, 5'd17, 1'b1, 3'd2, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b0, 3'd0, 2'b00, 5'd0, 5'd0, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            sample();
            checks++;
            if (is_stall !== 1'b1) begin errors++; $display("FAIL ecall_stall_%0d: got %b want 1", k, is_stall); end
            tick();
        end
        sample();
        checks++;
        if (is_stall !== 1'b0) begin errors++; $display("FAIL ecall_idle: got %b want 0", is_stall); end
        idle();
    endtask

    task automatic test_waw_zero();
        drive(1'b1, 5'd3, 1'b1, 3'd3, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd3, 1'b1, 3'd1, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            sample();
            checks++;
            if (is_stall !== 1'b1) begin errors++; $display("FAIL waw_stall_%0d: got %b want 1", k, is_stall); end
            tick();
        end
        sample();
        checks++;
        if (is_stall !== 1'b0) begin errors++; $display("FAIL waw_accept: got %b want 0", is_stall); end
        tick();
        // the reload of 1 must hold rd=3 busy for one more cycle
        drive(1'b1, 5'd0, 1'b0, 3'd0, 2'b01, 5'd0, 5'd3, 1'b0, 1'b0);
        sample();
        checks++;
        if (is_stall !== 1'b1) begin errors++; $display("FAIL waw_reload_stall: got %b want 1", is_stall); end
        checks++;
        if (busy_mask !== 32'h0000_0008) begin errors++; $display("FAIL waw_reload_busy: got %h want %h", busy_mask, 32'h8); end
        tick();
        sample();
        checks++;
        if (is_stall !== 1'b0) begin errors++; $display("FAIL waw_done: got %b want 0", is_stall); end
        drive(1'b1, 5'd0, 1'b1, 3'd4, 2'b11, 5'd0, 5'd0, 1'b0, 1'b0);
        sample();
        checks++;
        if (is_stall !== 1'b0) begin errors++; $display("FAIL zero_issue_stall: got %b want 0", is_stall); end
        tick();
        sample();
        checks++;
        if (busy_mask !== 32'h0) begin errors++; $display("FAIL zero_busy: got %h want 0", busy_mask); end
        checks++;
        if (is_stall !== 1'b0) begin errors++; $display("FAIL zero_src_stall: got %b want 0", is_stall); end
        idle();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 5'd1, 1'b1, 3'd2, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd2, 1'b1, 3'd1, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        idle();
        sample();
        checks++;
        if (busy_mask !== 32'h0000_0006) begin errors++; $display("FAIL b2b_busy: got %h want %h", busy_mask, 32'h6); end
        tick();
        sample();
        checks++;
        if (busy_mask !== 32'h0) begin errors++; $display("FAIL b2b_clear: got %h want 0", busy_mask); end
    endtask

    task automatic test_flush_reset();
        drive(1'b1, 5'd9, 1'b1, 3'd3, 2'b00, 5'd0, 5'd0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 5'd0, 1'b0, 3'd0, 2'b01, 5'd0, 5'd9, 1'b0, 1'b0);
        sample();
        checks++;
        if (busy_mask !== 32'h0) begin errors++; $display("FAIL flush_busy: got %h want 0", busy_mask); end
        checks++;
        if (is_stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", is_stall); end
        tick();
        drive(1'b1, 5'd4, 1'b1, 3'd3, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b0, 3'd0, 2'b01, 5'd0, 5'd4, 1'b0, 1'b0);
        tick();
        sample();
        checks++;
        if (busy_mask !== 32'h0000_0010) begin errors++; $display("FAIL rst_pre_busy: got %h want %h", busy_mask, 32'h10); end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (busy_mask !== 32'h0) begin errors++; $display("FAIL rst_async_busy: got %h want 0", busy_mask); end
        checks++;
        if (is_stall !== 1'b0) begin errors++; $display("FAIL rst_async_stall: got %b want 0", is_stall); end
        tick();
        reset = 1'b0;
        drive(1'b1, 5'd6, 1'b1, 3'd2, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        idle();
        sample();
        checks++;
        if (busy_mask !== 32'h0000_0040) begin errors++; $display("FAIL first_accept: got %h want %h", busy_mask, 32'h40); end
        tick();
        tick();
    endtask

    task automatic test_perf();
        logic [31:0] exp_cnt;
`ifdef HAZARD_SCOREBOARD_PERF_EN
        exp_cnt = 32'd6;
`else
        exp_cnt = 32'd0;
`endif
        reset = 1'b1;
        #1;
        checks++;
        if (stall_cycles !== 32'd0) begin errors++; $display("FAIL perf_reset: got %0d want 0", stall_cycles); end
        tick();
        reset = 1'b0;
        drive(1'b1, 5'd8, 1'b1, 3'd6, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b0, 3'd0, 2'b01, 5'd0, 5'd8, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) tick();
        sample();
        checks++;
        if (is_stall !== 1'b0) begin errors++; $display("FAIL perf_release: got %b want 0", is_stall); end
        checks++;
        if (stall_cycles !== exp_cnt) begin errors++; $display("FAIL perf_count: got %0d want %0d", stall_cycles, exp_cnt); end
        idle();
        tick();
        tick();
        sample();
        checks++;
        if (stall_cycles !== exp_cnt) begin errors++; $display("FAIL perf_hold: got %0d want %0d", stall_cycles, exp_cnt); end
        reset = 1'b1;
        #1;
        checks++;
        if (stall_cycles !== 32'd0) begin errors++; $display("FAIL perf_clear: got %0d want 0", stall_cycles); end
        tick();
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_long_latency();
        test_ecall();
        test_waw_zero();
        test_back_to_back();
        test_flush_reset();
        test_perf();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
